// File: rtl/rv32_m_arbiter.sv
// Round-robin arbiter/sequencer sharing one multiply/divide unit between N_REQ requesters.
// Latches the winner's operands, drives a one-cycle start, routes the result back, aborts on timeout.
module rv32_m_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned XLEN    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*XLEN-1:0] i_rs1,
  input  logic [N_REQ*XLEN-1:0] i_rs2,
  input  logic [N_REQ*3-1:0]    i_f3,
  output logic [N_REQ-1:0]      o_ack,
  output logic [XLEN-1:0]       o_res,
  output logic                  o_err,
  output logic                  o_busy,
  output logic                  o_m_en,
  output logic [XLEN-1:0]       o_m_rs1,
  output logic [XLEN-1:0]       o_m_rs2,
  output logic [2:0]            o_m_f3,
  input  logic [XLEN-1:0]       i_m_res,
  input  logic                  i_m_ack
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic [WD_W-1:0]  wdog_q;

  logic             win_vld_c;
  logic [IDX_W-1:0] win_idx_c;

  // (base + off) mod N_REQ, valid for N_REQ that is not a power of two
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    logic [IDX_W:0] s;
    s = {1'b0, base} + (IDX_W+1)'(off);
    if (s >= (IDX_W+1)'(N_REQ)) s = s - (IDX_W+1)'(N_REQ);
    return s[IDX_W-1:0];
  endfunction

  // Scan downward so the candidate nearest the pointer is written last and wins
  always_comb begin
    win_vld_c = |i_req;
    win_idx_c = ptr_q;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (i_req[wrap_add(ptr_q, i)]) win_idx_c = wrap_add(ptr_q, i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      wdog_q  <= '0;
      o_ack   <= '0;
      o_res   <= '0;
      o_err   <= 1'b0;
      o_busy  <= 1'b0;
      o_m_en  <= 1'b0;
      o_m_rs1 <= '0;
      o_m_rs2 <= '0;
      o_m_f3  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld_c) begin
            grant_q <= win_idx_c;
            o_m_rs1 <= i_rs1[win_idx_c*XLEN +: XLEN];
            o_m_rs2 <= i_rs2[win_idx_c*XLEN +: XLEN];
            o_m_f3  <= i_f3[win_idx_c*3 +: 3];
            o_m_en  <= 1'b1;
            o_busy  <= 1'b1;
            wdog_q  <= '0;
            state_q <= S_GRANT;
          end
        end
        // Watchdog counts cycles elapsed since the start pulse
        S_GRANT: begin
          o_m_en  <= 1'b0;
          wdog_q  <= WD_W'(1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_m_ack) begin
            o_res   <= i_m_res;
            o_ack   <= N_REQ'(1) << grant_q;
            o_err   <= 1'b0;
            o_busy  <= 1'b0;
            state_q <= S_DONE;
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            o_res   <= '0;
            o_ack   <= N_REQ'(1) << grant_q;
            o_err   <= 1'b1;
            o_busy  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        S_DONE: begin
          o_ack   <= '0;
          o_err   <= 1'b0;
          o_res   <= '0;
          ptr_q   <= wrap_add(grant_q, 1);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
